i2c_write_nbyte: RTL and testbench
==================================

I2C_WRITE_NBYTE -- requirements
Module: i2c_write_nbyte

Interface
REQ-001 Parameter DIV, default 4: PT_CK cycles per I2C phase, legal range 1..255.
REQ-002 Parameter PTR_BYTES, default 1: register-pointer length in bytes, legal values 1 or 2.
REQ-003 Parameter MAX_DATA, default 4: maximum data bytes per transaction, legal range 1..7.
REQ-004 PT_CK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 GO  in  1  start request, level-sampled in IDLE.
REQ-007 SLAVE_ADDRESS  in  8  first byte on the wire; bits [7:1] address, bit 0 R/W, sent as given.
REQ-008 POINTER  in  8*PTR_BYTES  register pointer, MS byte sent first.
REQ-009 WDATA  in  8*MAX_DATA  data; byte k = WDATA[8k+7:8k], k=0 sent first.
REQ-010 NBYTES  in  3  data byte count; 0 = pointer-only write.
REQ-011 SDAI  in  1  SDA line readback.
REQ-012 SDAO  out  1  SDA drive; 1 = release.
REQ-013 SCLO  out  1  SCL drive.
REQ-014 BUSY  out  1  transaction in progress.
REQ-015 END_OK  out  1  one-cycle completion pulse.
REQ-016 ACK_OK  out  1  last transaction fully ACKed.
REQ-017 NACK_ERR  out  1  last transaction aborted on NACK.
REQ-018 BYTE_CNT  out  4  index of the byte on the wire; 0 = address.

Function
REQ-019 Phase timer counts 0..DIV-1; a phase ends when the count reaches DIV-1; the timer clears on every state change.
REQ-020 States: IDLE, START, BIT (4 phases), STOP (3 phases), DONE.
REQ-021 IDLE: SDAO=1, SCLO=1, BUSY=0; GO=1 latches SLAVE_ADDRESS, POINTER, WDATA and min(NBYTES,MAX_DATA), clears ACK_OK/NACK_ERR, and moves to START.
REQ-022 START: SDAO=0, SCLO=1 for one phase, then BIT.
REQ-023 BIT phases: p0 SCLO=0 with SDAO set to the current bit (MSB first; 9th bit SDAO=1); p1 SCLO=0; p2 SCLO=1 with SDAI sampled at phase end; p3 SCLO=1.
REQ-024 Frame length B = 1+PTR_BYTES+NBYTES bytes of 9 bits each; BYTE_CNT increments after every 9th bit.
REQ-025 SDAI=1 at the 9th-bit sample of any byte is a NACK: remaining bytes are skipped and the block enters STOP.
REQ-026 STOP: SDAO=0,SCLO=0 for one phase; SDAO=0,SCLO=1 for one phase; SDAO=1,SCLO=1 for one phase; then DONE.
REQ-027 DONE, one cycle: END_OK=1, BUSY=0, ACK_OK=1 if no NACK occurred, NACK_ERR=1 otherwise; next state IDLE.
REQ-028 BUSY is 1 from the cycle after acceptance through the last STOP cycle, exactly DIV*(4+36*B) cycles without NACK.
REQ-029 GO is ignored while BUSY=1; GO held high re-triggers from IDLE on the cycle after DONE.
REQ-030 Input changes after acceptance do not affect the frame in progress.

Reset
REQ-031 RESET=1 at any edge forces IDLE: SDAO=1, SCLO=1, BUSY=0, END_OK=0, ACK_OK=0, NACK_ERR=0, BYTE_CNT=0, timer=0.
REQ-032 Reset mid-frame releases the bus on the next edge, generates no STOP, and produces no END_OK.

Configuration
REQ-033 Macro I2C_WRITE_RETRY_EN defined: after a NACK, the block completes STOP, waits 4*DIV idle cycles with the bus released, then restarts the frame from START; at most 3 retries; END_OK only after success or the final NACK; BUSY stays high throughout.
REQ-034 Macro I2C_WRITE_RETRY_EN undefined: no retry; a NACK leads directly to STOP, DONE and NACK_ERR=1.

Verification
REQ-035 DIV=2, PTR_BYTES=1, NBYTES=1, SLAVE_ADDRESS=8'h18, POINTER=8'h03, WDATA[7:0]=8'hA5, all ACK -> SDAO bits 00011000,00000011,10100101; BUSY 224 cycles; END_OK pulse; ACK_OK=1.
REQ-036 PTR_BYTES=2, NBYTES=0, POINTER=16'h1234 -> bytes 12 then 34 after the address; B=3; ACK_OK=1.
REQ-037 SDAI=1 at the 2nd byte's ACK (retry off) -> no data bytes sent; STOP; NACK_ERR=1, ACK_OK=0, BYTE_CNT=1 at DONE.
REQ-038 NBYTES=7 with MAX_DATA=4 -> exactly 4 data bytes sent, WDATA[7:0] first.
REQ-039 RESET pulsed during bit 5 of byte 1 -> next cycle SDAO=1, SCLO=1, BUSY=0; END_OK never asserts.
REQ-040 I2C_WRITE_RETRY_EN defined, NACK on 2 attempts then ACK -> 3 START conditions seen, single END_OK, ACK_OK=1, NACK_ERR=0.

Source files
------------

// File: rtl/i2c_write_nbyte.sv
// i2c_write_nbyte: I2C master write of address, register pointer and up to MAX_DATA data bytes; define I2C_WRITE_RETRY_EN to retry NACKed frames
module i2c_write_nbyte #(
  parameter int DIV = 4,
  parameter int PTR_BYTES = 1,
  parameter int MAX_DATA = 4
) (
  input  logic                    PT_CK,
  input  logic                    RESET,
  input  logic                    GO,
  input  logic [7:0]              SLAVE_ADDRESS,
  input  logic [8*PTR_BYTES-1:0]  POINTER,
  input  logic [8*MAX_DATA-1:0]   WDATA,
  input  logic [2:0]              NBYTES,
  input  logic                    SDAI,
  output logic                    SDAO,
  output logic                    SCLO,
  output logic                    BUSY,
  output logic                    END_OK,
  output logic                    ACK_OK,
  output logic                    NACK_ERR,
  output logic [3:0]              BYTE_CNT
);
  localparam int FW = 8 * (1 + PTR_BYTES + MAX_DATA);
  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_WAIT, S_DONE} state_t;
  state_t r_st, w_nx;
  logic [9:0] r_tmr;
  logic [1:0] r_ph;
  logic [3:0] r_bit, r_byte, r_b;
  logic [FW-1:0] r_fl, r_sh;
  logic [8*MAX_DATA-1:0] w_wrev;
  logic [2:0] w_nb;
  logic r_sda, r_nack, r_ack, r_nerr;
  logic w_go, w_tend, w_bend, w_yend, w_send, w_retry;
  assign w_go = r_st == S_IDLE && GO;
  assign w_tend = r_tmr == (r_st == S_WAIT ? 10'(4 * DIV - 1) : 10'(DIV - 1));
  assign w_bend = r_st == S_BIT && r_ph == 2'd3 && w_tend;
  assign w_yend = w_bend && r_bit == 4'd8;
  assign w_send = r_st == S_STOP && r_ph == 2'd2 && w_tend;
  assign w_nb = NBYTES > 3'(MAX_DATA) ? 3'(MAX_DATA) : NBYTES;
  assign ACK_OK = r_ack;
  assign NACK_ERR = r_nerr;
  assign BYTE_CNT = r_byte;
  // byte-reverse the data word so byte 0 lands right after the pointer in the MSB-first frame
  always_comb begin
    w_wrev = '0;
    for (int k = 0; k < MAX_DATA; k++) w_wrev[8*(MAX_DATA-1-k) +: 8] = WDATA[8*k +: 8];
  end
`ifdef I2C_WRITE_RETRY_EN
  logic [1:0] r_try;
  // count restarts taken after a NACK
  always_ff @(posedge PT_CK)
    if (RESET || w_go) r_try <= '0;
    else if (r_st == S_WAIT && w_tend) r_try <= r_try + 2'd1;
  assign w_retry = r_nack && r_try != 2'd3;
`else
  assign w_retry = 1'b0;
`endif
  // state register
  always_ff @(posedge PT_CK) r_st <= RESET ? S_IDLE : w_nx;
  // next state and bus drive
  always_comb begin
    w_nx = r_st;
    SDAO = 1'b1;
    SCLO = 1'b1;
    BUSY = 1'b1;
    END_OK = 1'b0;
    case (r_st)
      S_IDLE: begin
        BUSY = 1'b0;
        w_nx = GO ? S_START : S_IDLE;
      end
      S_START: begin
        SDAO = 1'b0;
        w_nx = w_tend ? S_BIT : S_START;
      end
      S_BIT: begin
        SDAO = r_bit == 4'd8 || r_sh[FW-1];
        SCLO = r_ph[1];
        w_nx = w_yend && (r_sda || r_byte + 4'd1 == r_b) ? S_STOP : S_BIT;
      end
      S_STOP: begin
        SDAO = r_ph == 2'd2;
        SCLO = r_ph != 2'd0;
        w_nx = !w_send ? S_STOP : w_retry ? S_WAIT : S_DONE;
      end
      S_WAIT: w_nx = w_tend ? S_START : S_WAIT;
      default: begin
        BUSY = 1'b0;
        END_OK = 1'b1;
        w_nx = S_IDLE;
      end
    endcase
  end
  // phase timer, phase index within a bit or STOP, bit index within a byte
  always_ff @(posedge PT_CK) begin
    r_tmr <= (RESET || r_st == S_IDLE || w_nx != r_st || w_tend) ? '0 : r_tmr + 10'd1;
    r_ph <= (RESET || w_nx != r_st) ? '0 : (w_tend && (r_st == S_BIT || r_st == S_STOP)) ? r_ph + 2'd1 : r_ph;
    r_bit <= (RESET || r_st != S_BIT) ? '0 : w_bend ? (r_bit == 4'd8 ? 4'd0 : r_bit + 4'd1) : r_bit;
  end
  // frame capture, shift-out register and ACK sampling
  always_ff @(posedge PT_CK) begin
    if (w_go) r_fl <= {SLAVE_ADDRESS, POINTER, w_wrev};
    if (w_go) r_b <= 4'(1 + PTR_BYTES) + {1'b0, w_nb};
    if (r_st == S_START) r_sh <= r_fl;
    else if (w_bend && r_bit != 4'd8) r_sh <= r_sh << 1;
    if (r_st == S_BIT && r_ph == 2'd2 && w_tend) r_sda <= SDAI;
  end
  // byte counter and completion status
  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      r_byte <= '0;
      r_nack <= 1'b0;
      r_ack <= 1'b0;
      r_nerr <= 1'b0;
    end else begin
      if (w_go || r_st == S_WAIT) begin
        r_byte <= '0;
        r_nack <= 1'b0;
      end
      if (w_go) begin
        r_ack <= 1'b0;
        r_nerr <= 1'b0;
      end
      if (w_yend && r_sda) r_nack <= 1'b1;
      else if (w_yend) r_byte <= r_byte + 4'd1;
      if (w_send && !w_retry) begin
        r_ack <= !r_nack;
        r_nerr <= r_nack;
      end
    end
  end
endmodule

// File: tb/tb_i2c_write_nbyte.sv
// tb_i2c_write_nbyte: directed self-checking bench decoding the I2C wire of two configurations
module tb_i2c_write_nbyte;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, go = 1'b0, sel = 1'b0, nack_on = 1'b0;
  logic [7:0] addr = '0;
  logic [15:0] ptr = '0;
  logic [31:0] wd = '0;
  logic [2:0] nb = '0;
  int nack_max = 0;
  logic sdao0, scl0, busy0, end0, ack0, nerr0, sdao1, scl1, busy1, end1, ack1, nerr1;
  logic [3:0] bc0, bc1;
  logic w_sda, w_scl, w_busy, w_end, w_ack, w_nerr, sdai;
  logic [3:0] w_bc;
  int n_chk = 0, n_err = 0;
  int mon_starts = 0, mon_stops = 0, mon_nb = 0, mon_bc = 0, mon_busy = 0, mon_end = 0;
  int b_starts = 0, b_stops = 0, b_nb = 0, b_busy = 0, b_end = 0;
  logic [7:0] mon_cur = '0;
  logic [7:0] mon_byte [0:255];
  logic d_ack = 1'b0, d_nerr = 1'b0;
  logic [3:0] d_bc = '0;
  logic p_scl = 1'b1, p_sda = 1'b1;
  assign w_sda = sel ? sdao1 : sdao0;
  assign w_scl = sel ? scl1 : scl0;
  assign w_busy = sel ? busy1 : busy0;
  assign w_end = sel ? end1 : end0;
  assign w_ack = sel ? ack1 : ack0;
  assign w_nerr = sel ? nerr1 : nerr0;
  assign w_bc = sel ? bc1 : bc0;
  assign sdai = nack_on && w_bc == 4'd1 && (mon_starts - b_starts) <= nack_max;

  i2c_write_nbyte #(.DIV(2), .PTR_BYTES(1), .MAX_DATA(4)) u0 (
    .PT_CK(clk), .RESET(rst), .GO(go && !sel), .SLAVE_ADDRESS(addr), .POINTER(ptr[7:0]),
    .WDATA(wd), .NBYTES(nb), .SDAI(sdai), .SDAO(sdao0), .SCLO(scl0), .BUSY(busy0),
    .END_OK(end0), .ACK_OK(ack0), .NACK_ERR(nerr0), .BYTE_CNT(bc0));
  i2c_write_nbyte #(.DIV(2), .PTR_BYTES(2), .MAX_DATA(4)) u1 (
    .PT_CK(clk), .RESET(rst), .GO(go && sel), .SLAVE_ADDRESS(addr), .POINTER(ptr),
    .WDATA(wd), .NBYTES(nb), .SDAI(sdai), .SDAO(sdao1), .SCLO(scl1), .BUSY(busy1),
    .END_OK(end1), .ACK_OK(ack1), .NACK_ERR(nerr1), .BYTE_CNT(bc1));

  always @(negedge clk) begin
    if (w_scl && p_scl && p_sda && !w_sda) begin
      mon_starts <= mon_starts + 1;
      mon_bc <= 0;
    end else if (w_scl && !p_scl) begin
      if (mon_bc < 8) mon_cur <= {mon_cur[6:0], w_sda};
      if (mon_bc == 7) begin
        mon_byte[mon_nb] <= {mon_cur[6:0], w_sda};
        mon_nb <= mon_nb + 1;
      end
      mon_bc <= mon_bc == 8 ? 0 : mon_bc + 1;
    end
    if (w_scl && p_scl && !p_sda && w_sda) mon_stops <= mon_stops + 1;
    if (w_busy) mon_busy <= mon_busy + 1;
    if (w_end) begin
      mon_end <= mon_end + 1;
      d_ack <= w_ack;
      d_nerr <= w_nerr;
      d_bc <= w_bc;
    end
    p_scl <= w_scl;
    p_sda <= w_sda;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit s, input logic [7:0] a, input logic [15:0] p, input logic [31:0] d,
                     input logic [2:0] n, input bit nk, input int nkm);
    @(negedge clk);
    sel = s; addr = a; ptr = p; wd = d; nb = n; nack_on = nk; nack_max = nkm;
    b_starts = mon_starts; b_stops = mon_stops; b_nb = mon_nb; b_busy = mon_busy; b_end = mon_end;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0; addr = 8'hFF; ptr = 16'hFFFF; wd = '1; nb = 3'd5;
    repeat (40) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 4000 && mon_end == b_end; i++) @(negedge clk);
    chk("end_seen", 32'(mon_end != b_end), 1);
    repeat (3) @(negedge clk);
    chk("idle_after", 32'(w_busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_u0", {sdao0, scl0, busy0, end0, ack0, nerr0, bc0}, 10'b1100000000);
    chk("rst_u1", {sdao1, scl1, busy1, end1, ack1, nerr1, bc1}, 10'b1100000000);
    rst = 1'b0;
    run(1'b0, 8'h18, 16'h0003, 32'h000000A5, 3'd1, 1'b0, 0);
    chk("w1_nbytes", mon_nb - b_nb, 3);
    chk("w1_b0", mon_byte[b_nb], 8'h18);
    chk("w1_b1", mon_byte[b_nb + 1], 8'h03);
    chk("w1_b2", mon_byte[b_nb + 2], 8'hA5);
    chk("w1_starts", mon_starts - b_starts, 1);
    chk("w1_stops", mon_stops - b_stops, 1);
    chk("w1_busy", mon_busy - b_busy, 224);
    chk("w1_endok", mon_end - b_end, 1);
    chk("w1_status", {d_ack, d_nerr, d_bc}, 6'b10_0011);
    run(1'b0, 8'h18, 16'h0003, 32'h44332211, 3'd7, 1'b0, 0);
    chk("clamp_nbytes", mon_nb - b_nb, 6);
    chk("clamp_d0", mon_byte[b_nb + 2], 8'h11);
    chk("clamp_d1", mon_byte[b_nb + 3], 8'h22);
    chk("clamp_d2", mon_byte[b_nb + 4], 8'h33);
    chk("clamp_d3", mon_byte[b_nb + 5], 8'h44);
    chk("clamp_busy", mon_busy - b_busy, 440);
    chk("clamp_status", {d_ack, d_nerr, d_bc}, 6'b10_0110);
    run(1'b1, 8'h18, 16'h1234, 32'h0, 3'd0, 1'b0, 0);
    chk("ptr2_nbytes", mon_nb - b_nb, 3);
    chk("ptr2_b0", mon_byte[b_nb], 8'h18);
    chk("ptr2_b1", mon_byte[b_nb + 1], 8'h12);
    chk("ptr2_b2", mon_byte[b_nb + 2], 8'h34);
    chk("ptr2_busy", mon_busy - b_busy, 224);
    chk("ptr2_status", {d_ack, d_nerr, d_bc}, 6'b10_0011);
`ifndef I2C_WRITE_RETRY_EN
    run(1'b0, 8'h18, 16'h0003, 32'h000000A5, 3'd2, 1'b1, 1);
    chk("nack_nbytes", mon_nb - b_nb, 2);
    chk("nack_stops", mon_stops - b_stops, 1);
    chk("nack_busy", mon_busy - b_busy, 152);
    chk("nack_endok", mon_end - b_end, 1);
    chk("nack_status", {d_ack, d_nerr, d_bc}, 6'b01_0001);
`else
    run(1'b0, 8'h18, 16'h0003, 32'h000000A5, 3'd1, 1'b1, 2);
    chk("retry_starts", mon_starts - b_starts, 3);
    chk("retry_nbytes", mon_nb - b_nb, 7);
    chk("retry_endok", mon_end - b_end, 1);
    chk("retry_status", {d_ack, d_nerr, d_bc}, 6'b10_0011);
`endif
    @(negedge clk);
    sel = 1'b0; addr = 8'h18; ptr = 16'h0003; wd = 32'hA5; nb = 3'd1; nack_on = 1'b0;
    b_nb = mon_nb; b_end = mon_end;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 500 && !(mon_nb - b_nb == 1 && mon_bc == 5); i++) @(negedge clk);
    chk("mid_reached", 32'(mon_nb - b_nb == 1 && mon_bc == 5), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_release", {sdao0, scl0, busy0, bc0}, 7'b1100000);
    b_busy = mon_busy;
    repeat (300) @(negedge clk);
    chk("mid_no_endok", mon_end - b_end, 0);
    chk("mid_no_busy", mon_busy - b_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
